cmp_seq: RTL and testbench



---
 rtl/cmp_seq.sv | 149 ++++++++++++++
 tb/tb_cmp_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq.sv
// cmp_seq: multi-mode chunked integer comparator for the ALU compare path.
// Scans operands MSB-first CHUNK bits per clock; mask result over valid/ready.
module cmp_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] cmpout,
  output logic             flag,
  output logic             err
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       md_q, md_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             dec_q, dec_d;
  logic             lt_q, lt_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             flag_q, flag_d;
  logic             err_q, err_d;

  logic [CHUNK-1:0] ach, bch;
  logic             diff, dnow, ltnow, res, sgn, rsv, fin;

  // Operands shift left each step, so the live chunk is always the top one.
  assign ach = a_q[WIDTH-1 -: CHUNK];
  assign bch = b_q[WIDTH-1 -: CHUNK];
  assign diff  = (ach != bch);
  assign dnow  = dec_q | diff;
  assign ltnow = dec_q ? lt_q : (ach < bch);
  assign sgn = (mode == 3'b010) | (mode == 3'b100);
  assign rsv = mode[2] & mode[1];
  assign fin = ((EARLY_EXIT != 0) && diff && !dec_q) || (idx_q == '0);

  always_comb begin
    res = 1'b0;
    case (md_q)
      3'b000:         res = !dnow;
      3'b001:         res = dnow;
      3'b010, 3'b011: res = dnow && ltnow;
      3'b100, 3'b101: res = !(dnow && ltnow);
      default:        res = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    md_d    = md_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    lt_d    = lt_q;
    cmp_d   = cmp_q;
    flag_d  = flag_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = sgn ? (inA ^ MSB) : inA;
          b_d   = sgn ? (inB ^ MSB) : inB;
          md_d  = mode;
          idx_d = IW'(NCH - 1);
          dec_d = 1'b0;
          lt_d  = 1'b0;
          if (rsv) begin
            state_d = DONE;
            cmp_d   = '0;
            flag_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        dec_d = dnow;
        lt_d  = dnow && ltnow;
        a_d   = a_q << CHUNK;
        b_d   = b_q << CHUNK;
        if (fin) begin
          state_d = DONE;
          cmp_d   = {WIDTH{res}};
          flag_d  = !res;
          err_d   = 1'b0;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      md_q    <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      cmp_q   <= '0;
      flag_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      md_q    <= md_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      lt_q    <= lt_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cmpout    = cmp_q;
  assign flag      = flag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: directed vectors against early-exit and fixed-latency cmp_seq.
// Both instances see identical stimulus; latency is checked per instance.
module tb_cmp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] inA = '0, inB = '0;
  logic [2:0]  mode = '0;

  logic        rdy1, v1, f1, e1;
  logic        rdy0, v0, f0, e0;
  logic [31:0] c1, c0;

  int napplied = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  cmp_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy1),
    .inA(inA), .inB(inB), .mode(mode),
    .out_valid(v1), .out_ready(out_ready),
    .cmpout(c1), .flag(f1), .err(e1)
  );

  cmp_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy0),
    .inA(inA), .inB(inB), .mode(mode),
    .out_valid(v0), .out_ready(out_ready),
    .cmpout(c0), .flag(f0), .err(e0)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
    logic        res;
    logic        er;
    int          l1;
    int          l0;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    napplied++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] m);
    inA = a;
    inB = b;
    mode = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    inA = 32'h5A5A_A5A5;
    inB = 32'h0F0F_F0F0;
    mode = 3'b001;
  endtask

  // Latency = rising edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int l1, output int l0);
    int c;
    c = 0;
    l1 = -1;
    l0 = -1;
    while (c < 40) begin
      if (v1 && l1 < 0) l1 = c;
      if (v0 && l0 < 0) l0 = c;
      if (l1 >= 0 && l0 >= 0) break;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ret_rdy", {rdy1, rdy0}, 2'b11);
    chk("ret_vld", {v1, v0}, 2'b00);
  endtask

  initial begin
    int l1, l0;
    logic seen;
    logic [31:0] ex;

    vecs[0]  = '{32'h0000_0001, 32'h0000_0002, 3'b011, 1'b1, 1'b0, 4, 4};
    vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 3'b010, 1'b1, 1'b0, 1, 4};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 3'b011, 1'b0, 1'b0, 1, 4};
    vecs[3]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000, 1'b1, 1'b0, 4, 4};
    vecs[4]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b001, 1'b0, 1'b0, 4, 4};
    vecs[5]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b101, 1'b1, 1'b0, 4, 4};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0000, 3'b100, 1'b0, 1'b0, 1, 4};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0000, 3'b101, 1'b1, 1'b0, 1, 4};
    vecs[8]  = '{32'h1234_5678, 32'h1234_5678, 3'b110, 1'b0, 1'b1, 0, 0};
    vecs[9]  = '{32'h0000_0000, 32'hFFFF_FFFF, 3'b111, 1'b0, 1'b1, 0, 0};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b010, 1'b0, 1'b0, 4, 4};
    vecs[11] = '{32'h1234_0000, 32'h1235_0000, 3'b011, 1'b1, 1'b0, 2, 4};
    vecs[12] = '{32'h0001_0000, 32'h0002_0000, 3'b100, 1'b0, 1'b0, 2, 4};
    vecs[13] = '{32'h0000_00AA, 32'h0000_00AB, 3'b001, 1'b1, 1'b0, 4, 4};
    vecs[14] = '{32'h0100_0000, 32'h0000_0000, 3'b000, 1'b0, 1'b0, 1, 4};
    vecs[15] = '{32'h0000_3300, 32'h0000_2200, 3'b010, 1'b0, 1'b0, 3, 4};

    @(negedge clk);
    chk("rst_rdy", {rdy1, rdy0}, 2'b11);
    chk("rst_vld", {v1, v0}, 2'b00);
    chk("rst_cmp", {c1, c0}, 64'h0);
    chk("rst_flag", {f1, f0}, 2'b11);
    chk("rst_err", {e1, e0}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      start(vecs[i].a, vecs[i].b, vecs[i].m);
      wait_done(l1, l0);
      ex = {32{vecs[i].res}};
      chk($sformatf("v%0d_lat_ee", i), 64'(l1), 64'(vecs[i].l1));
      chk($sformatf("v%0d_lat_fix", i), 64'(l0), 64'(vecs[i].l0));
      chk($sformatf("v%0d_cmp", i), {c1, c0}, {ex, ex});
      chk($sformatf("v%0d_flag", i), {f1, f0}, {2{!vecs[i].res}});
      chk($sformatf("v%0d_err", i), {e1, e0}, {2{vecs[i].er}});
      retire();
    end

    // Backpressure: result held, new requests ignored while DONE.
    start(32'h0000_0001, 32'h0000_0002, 3'b011);
    chk("bp_busy_rdy", {rdy1, rdy0}, 2'b00);
    wait_done(l1, l0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      inA = 32'hFFFF_FFFF;
      mode = 3'b000;
      @(negedge clk);
      chk("bp_vld", {v1, v0}, 2'b11);
      chk("bp_rdy", {rdy1, rdy0}, 2'b00);
      chk("bp_cmp", {c1, c0}, {2{32'hFFFF_FFFF}});
      chk("bp_flag", {f1, f0}, 2'b00);
    end
    in_valid = 1'b0;
    retire();
    chk("bp_hold_cmp", {c1, c0}, {2{32'hFFFF_FFFF}});
    chk("bp_hold_flag", {f1, f0}, 2'b00);

    // Reset while BUSY aborts with no result.
    start(32'h0000_0001, 32'h0000_0002, 3'b011);
    @(negedge clk);
    chk("ab_busy_vld", {v1, v0}, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("ab_vld", {v1, v0}, 2'b00);
    chk("ab_flag", {f1, f0}, 2'b11);
    chk("ab_rdy", {rdy1, rdy0}, 2'b11);
    chk("ab_cmp", {c1, c0}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | v1 | v0;
    end
    chk("ab_noresult", 64'(seen), 64'h0);

    // Block still usable after the abort.
    start(32'h8000_0000, 32'h0000_0001, 3'b010);
    wait_done(l1, l0);
    chk("post_lat_ee", 64'(l1), 64'd1);
    chk("post_cmp", {c1, c0}, {2{32'hFFFF_FFFF}});
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nmiss);
    $finish;
  end

endmodule
